tour_cmd_seq: RTL and testbench
===============================

# tour_cmd_seq

Sequencer that turns a solved knight's tour into motion commands. After the tour solver reports completion, it reads the 24 stored moves by index. Each knight move becomes two commands for the command processor: a vertical leg, then a horizontal leg. While idle, it passes UART commands straight through, so the command processor always has a single command source.

## Interface
- No parameters.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-high.
- start_tour  in  1  one-cycle pulse from the tour solver when its solution is complete.
- move  in  8  one-hot knight move at index mv_indx, supplied by the solver combinationally.
- mv_indx  out  5  index of the move being executed, 0..23.
- cmd_UART  in  16  command from the UART wrapper.
- cmd_rdy_UART  in  1  UART command valid.
- cmd  out  16  command presented to the command processor.
- cmd_rdy  out  1  cmd valid.
- clr_cmd_rdy  in  1  pulse from the command processor accepting cmd.
- send_resp  in  1  pulse from the command processor when the accepted command has completed.
- resp  out  8  response byte for the UART.

## Operation
- Command format:
  - cmd[15:12] is the opcode: 4'h2 = move, 4'h3 = move with fanfare.
  - cmd[11:4] is the heading: 8'h00 north (+y), 8'h7F south (-y), 8'h3F west (-x), 8'hBF east (+x).
  - cmd[3:0] is the number of squares.
- Move decode, bit i of move gives (dx, dy):
  - bit 0 (+1,+2), bit 1 (-1,+2), bit 2 (-2,+1), bit 3 (-2,-1)
  - bit 4 (-1,-2), bit 5 (+1,-2), bit 6 (+2,-1), bit 7 (+2,+1)
- Multi-hot move: the lowest set bit wins. move == 0 decodes as bit 0.
- Vertical command = {4'h2, north if dy > 0 else south, |dy|}.
- Horizontal command = {4'h3, east if dx > 0 else west, |dx|}.
- FSM states: IDLE, VERT, HOLD_V, HORZ, HOLD_H.
  - IDLE: cmd = cmd_UART and cmd_rdy = cmd_rdy_UART. On start_tour, clear mv_indx to 0 and go to VERT.
  - VERT: cmd = vertical command, cmd_rdy = 1. On clr_cmd_rdy, go to HOLD_V.
  - HOLD_V: cmd_rdy = 0. On send_resp, go to HORZ.
  - HORZ: cmd = horizontal command, cmd_rdy = 1. On clr_cmd_rdy, go to HOLD_H.
  - HOLD_H: cmd_rdy = 0. On send_resp: if mv_indx == 23, go to IDLE; otherwise increment mv_indx and go to VERT.
- resp = 8'hA5 in IDLE, and in HOLD_H when mv_indx == 23. Otherwise resp = 8'h5A.
- start_tour outside IDLE is ignored.
- clr_cmd_rdy or send_resp arriving in a state that does not wait for it is ignored.
- In states other than IDLE, cmd_rdy_UART and cmd_UART are ignored.

## Timing
- Reset values: state IDLE, mv_indx 0. Outputs then follow the IDLE pass-through: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, resp = 8'hA5.
- cmd, cmd_rdy and resp are combinational decodes of the registered state, mv_indx and move.
- The UART pass-through has zero latency.
- First tour cmd_rdy is high in the cycle after start_tour is sampled.
- cmd_rdy drops in the cycle after clr_cmd_rdy is sampled.
- The next leg's cmd_rdy rises in the cycle after send_resp is sampled.
- mv_indx updates on the same edge that enters VERT. move must be valid by the following clock.
- Reset mid-tour: immediate return to IDLE with mv_indx 0. The tour is abandoned and needs a new start_tour.
- Minimum of 4 handshake pulses per move, 96 per tour.

## Test plan
- Reset asserted mid-tour (state HORZ, mv_indx 7) -> next cycle IDLE, mv_indx 0, pass-through restored, resp 8'hA5.
- IDLE, cmd_UART 16'h2012, cmd_rdy_UART 1 -> cmd 16'h2012, cmd_rdy 1 the same cycle. start_tour held low -> mv_indx stays 0.
- start_tour pulse, move 8'h01 -> cmd 16'h2002 with cmd_rdy 1 the cycle after start_tour. After clr_cmd_rdy then send_resp -> cmd 16'h3BF1. resp is 8'h5A throughout.
- move 8'h08 -> 16'h27F1 then 16'h33F2. move 8'h40 -> 16'h27F1 then 16'h3BF2. move 8'h03 -> treated as 8'h01.
- Full tour with a bench model replying clr_cmd_rdy after 2 cycles and send_resp after 10 cycles:
  - mv_indx steps 0..23, exactly 48 commands are issued;
  - resp is 8'hA5 after the final send_resp;
  - the machine is back in IDLE.
- start_tour pulsed during HOLD_V at mv_indx 5 -> ignored, mv_indx stays 5. cmd_rdy_UART pulsed mid-tour -> cmd is unchanged.

Source files
------------

// File: rtl/tour_cmd_seq.sv
`default_nettype none
// tour_cmd_seq: replays a solved knight's tour as vertical/horizontal move
// commands; forwards UART commands unchanged while idle.
// Revision: 1.0
module tour_cmd_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_VERT   = 3'd1;
   localparam logic [2:0] S_HOLD_V = 3'd2;
   localparam logic [2:0] S_HORZ   = 3'd3;
   localparam logic [2:0] S_HOLD_H = 3'd4;

   localparam logic [4:0] C_LAST_MV = 5'd23;
   localparam logic [7:0] C_NORTH   = 8'h00;
   localparam logic [7:0] C_SOUTH   = 8'h7F;
   localparam logic [7:0] C_WEST    = 8'h3F;
   localparam logic [7:0] C_EAST    = 8'hBF;
   localparam logic [7:0] C_RESP_DONE = 8'hA5;
   localparam logic [7:0] C_RESP_BUSY = 8'h5A;

   logic [2:0]  state_q, state_d;
   logic [4:0]  mv_indx_q, mv_indx_d;
   logic        dx_pos, dy_pos;
   logic [3:0]  dx_mag, dy_mag;
   logic [15:0] vert_cmd, horz_cmd;

   assign mv_indx = mv_indx_q;

   // Lowest set bit wins; an all-zero move falls through to the bit-0 move.
   always_comb begin
      dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2;
      casez (move)
         8'b???????1: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
         8'b??????10: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
         8'b?????100: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
         8'b????1000: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
         8'b???10000: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
         8'b??100000: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
         8'b?1000000: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
         8'b10000000: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
         default:     begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
      endcase
   end

   assign vert_cmd = {4'h2, (dy_pos ? C_NORTH : C_SOUTH), dy_mag};
   assign horz_cmd = {4'h3, (dx_pos ? C_EAST : C_WEST), dx_mag};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mv_indx_q <= 5'd0;
      end else begin
         state_q   <= state_d;
         mv_indx_q <= mv_indx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mv_indx_d = mv_indx_q;
      case (state_q)
         S_IDLE: begin
            if (start_tour) begin
               state_d   = S_VERT;
               mv_indx_d = 5'd0;
            end
         end
         S_VERT:   if (clr_cmd_rdy) state_d = S_HOLD_V;
         S_HOLD_V: if (send_resp)   state_d = S_HORZ;
         S_HORZ:   if (clr_cmd_rdy) state_d = S_HOLD_H;
         S_HOLD_H: begin
            if (send_resp) begin
               if (mv_indx_q == C_LAST_MV) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_VERT;
                  mv_indx_d = mv_indx_q + 5'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Hold states keep presenting the leg just accepted, with cmd_rdy low.
   always_comb begin
      cmd     = cmd_UART;
      cmd_rdy = cmd_rdy_UART;
      resp    = C_RESP_BUSY;
      case (state_q)
         S_IDLE:   resp = C_RESP_DONE;
         S_VERT:   begin cmd = vert_cmd; cmd_rdy = 1'b1; end
         S_HOLD_V: begin cmd = vert_cmd; cmd_rdy = 1'b0; end
         S_HORZ:   begin cmd = horz_cmd; cmd_rdy = 1'b1; end
         S_HOLD_H: begin
            cmd     = horz_cmd;
            cmd_rdy = 1'b0;
            resp    = (mv_indx_q == C_LAST_MV) ? C_RESP_DONE : C_RESP_BUSY;
         end
         default: begin cmd = cmd_UART; cmd_rdy = 1'b0; end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd_seq.sv
`default_nettype none
// tb_tour_cmd_seq: scoreboard bench for tour_cmd_seq with a behavioural
// knight-move model and a timed command-processor responder.
module tb_tour_cmd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;

   tour_cmd_seq dut (
      .clk          (clk),
      .rst          (rst),
      .start_tour   (start_tour),
      .move         (move),
      .mv_indx      (mv_indx),
      .cmd_UART     (cmd_UART),
      .cmd_rdy_UART (cmd_rdy_UART),
      .cmd          (cmd),
      .cmd_rdy      (cmd_rdy),
      .clr_cmd_rdy  (clr_cmd_rdy),
      .send_resp    (send_resp),
      .resp         (resp)
   );

   always #10 clk = ~clk;

   logic [7:0]  moves_tab [32];
   assign move = moves_tab[mv_indx];

   int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
   int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_q [$];
   int          popped = 0;
   bit          in_tour = 1'b0;
   bit          auto_en = 1'b0;
   int          auto_legs = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: knight offset table -> {vertical command, horizontal command}.
   function automatic logic [31:0] ref_move(logic [7:0] mv);
      int k = 0;
      int dx, dy;
      logic [15:0] v, h;
      for (int i = 7; i >= 0; i--) if (mv[i]) k = i;
      dx = DX[k];
      dy = DY[k];
      v = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
      h = {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
      return {v, h};
   endfunction

   task automatic load_tour(bit rnd, logic [7:0] fixed);
      logic [31:0] vh;
      exp_q.delete();
      for (int i = 0; i < 32; i++) moves_tab[i] = 8'h00;
      for (int i = 0; i < 24; i++) begin
         if (rnd) begin
            moves_tab[i] = 8'($urandom);
            if ($urandom_range(0, 7) == 0) moves_tab[i] = 8'h00;
         end else begin
            moves_tab[i] = fixed;
         end
         vh = ref_move(moves_tab[i]);
         exp_q.push_back(vh[31:16]);
         exp_q.push_back(vh[15:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      in_tour    = 1'b1;
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
   endtask

   task automatic pulse_send();
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
   endtask

   task automatic leg();
      tick();
      pulse_clr();
      tick();
      pulse_send();
   endtask

   task automatic abort_reset();
      rst     = 1'b1;
      in_tour = 1'b0;
      tick();
      rst     = 1'b0;
      exp_q.delete();
   endtask

   // Monitor: every accepted tour command is popped from the scoreboard.
   always @(negedge clk) begin
      if (in_tour && cmd_rdy && clr_cmd_rdy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_cmd", 32'(cmd), 32'hFFFF_FFFF);
         end else begin
            check("cmd", 32'(cmd), 32'(exp_q.pop_front()));
            popped++;
         end
         check("resp_leg", 32'(resp), 32'h5A);
      end
   end

   // Command-processor model: clr after 2 cycles, send_resp after 10 more.
   initial begin
      forever begin
         @(negedge clk);
         if (auto_en && cmd_rdy) begin
            repeat (2) @(posedge clk);
            #1 clr_cmd_rdy = 1'b1;
            @(posedge clk);
            #1 clr_cmd_rdy = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            check("auto_mv_indx", 32'(mv_indx), 32'(auto_legs / 2));
            check("auto_resp", 32'(resp), (auto_legs == 47) ? 32'hA5 : 32'h5A);
            send_resp = 1'b1;
            @(posedge clk);
            #1 send_resp = 1'b0;
            auto_legs++;
         end
      end
   end

   task automatic first_leg(logic [7:0] mv, logic [15:0] ev, logic [15:0] eh);
      load_tour(1'b0, mv);
      start();
      check("first_rdy", 32'(cmd_rdy), 32'd1);
      check("first_vert", 32'(cmd), 32'(ev));
      check("first_resp", 32'(resp), 32'h5A);
      tick();
      pulse_clr();
      check("rdy_drop", 32'(cmd_rdy), 32'd0);
      check("hold_resp", 32'(resp), 32'h5A);
      tick();
      pulse_send();
      check("horz_rdy", 32'(cmd_rdy), 32'd1);
      check("first_horz", 32'(cmd), 32'(eh));
      pulse_clr();
      abort_reset();
   endtask

   task automatic full_tour();
      int p0;
      load_tour(1'b1, 8'h00);
      cmd_rdy_UART = 1'b0;
      p0 = popped;
      auto_legs = 0;
      auto_en = 1'b1;
      start();
      check("tour_start_idx", 32'(mv_indx), 32'd0);
      for (int c = 0; c < 3000 && auto_legs < 48; c++) @(negedge clk);
      auto_en = 1'b0;
      check("tour_legs", 32'(auto_legs), 32'd48);
      check("tour_cmds", 32'(popped - p0), 32'd48);
      check("tour_q_empty", 32'(exp_q.size()), 32'd0);
      check("tour_resp_done", 32'(resp), 32'hA5);
      in_tour = 1'b0;
      tick();
      cmd_UART = 16'($urandom);
      cmd_rdy_UART = 1'b1;
      #1;
      check("tour_idle_cmd", 32'(cmd), 32'(cmd_UART));
      check("tour_idle_rdy", 32'(cmd_rdy), 32'd1);
      cmd_rdy_UART = 1'b0;
   endtask

   initial begin
      logic [31:0] vh;
      rst = 1'b1; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
      for (int i = 0; i < 32; i++) moves_tab[i] = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      check("rst_idx", 32'(mv_indx), 32'd0);
      check("rst_resp", 32'(resp), 32'hA5);
      check("rst_rdy", 32'(cmd_rdy), 32'd0);

      cmd_UART = 16'h2012;
      cmd_rdy_UART = 1'b1;
      #1;
      check("pass_cmd", 32'(cmd), 32'h2012);
      check("pass_rdy", 32'(cmd_rdy), 32'd1);
      tick();
      tick();
      check("idle_idx", 32'(mv_indx), 32'd0);
      cmd_rdy_UART = 1'b0;
      tick();

      first_leg(8'h01, 16'h2002, 16'h3BF1);
      first_leg(8'h08, 16'h27F1, 16'h33F2);
      first_leg(8'h40, 16'h27F1, 16'h3BF2);
      first_leg(8'h03, 16'h2002, 16'h3BF1);

      // Manual walk: stray inputs at move 5, then reset in HORZ at move 7.
      load_tour(1'b1, 8'h00);
      start();
      for (int m = 0; m < 7; m++) begin
         if (m == 5) begin
            vh = ref_move(moves_tab[5]);
            cmd_UART = 16'hDEAD;
            cmd_rdy_UART = 1'b1;
            #1;
            check("uart_ignored", 32'(cmd), 32'(vh[31:16]));
            cmd_rdy_UART = 1'b0;
            pulse_send();
            check("send_ignored", 32'(cmd_rdy), 32'd1);
            pulse_clr();
            start_tour = 1'b1;
            tick();
            start_tour = 1'b0;
            check("start_ignored_idx", 32'(mv_indx), 32'd5);
            check("start_ignored_rdy", 32'(cmd_rdy), 32'd0);
            pulse_send();
            check("m5_horz", 32'(cmd), 32'(vh[15:0]));
            tick();
            pulse_clr();
            tick();
            pulse_send();
         end else begin
            leg();
            leg();
         end
      end
      check("m7_idx", 32'(mv_indx), 32'd7);
      leg();
      check("m7_horz_rdy", 32'(cmd_rdy), 32'd1);
      cmd_UART = 16'h1234;
      cmd_rdy_UART = 1'b0;
      rst = 1'b1;
      in_tour = 1'b0;
      #1;
      check("midrst_idx", 32'(mv_indx), 32'd0);
      check("midrst_cmd", 32'(cmd), 32'h1234);
      check("midrst_rdy", 32'(cmd_rdy), 32'd0);
      check("midrst_resp", 32'(resp), 32'hA5);
      tick();
      rst = 1'b0;
      exp_q.delete();
      tick();

      full_tour();
      full_tour();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
